laser_dot_pattern_gen: RTL and testbench

- Synthetic video source that drives a raster pixel stream carrying a horizontal red "laser" run at a programmable position.
- It is the transmitter end of the laser-detection pixel interface: it produces pixel_col, pixel_row and 24-bit data, which the detection pipeline consumes.
- Used for bring-up and regression of the image-processing IP without a camera. It replaces the camera front-end when selected.

---
 rtl/laser_dot_pattern_gen.sv | 164 ++++++++++++++++
 tb/tb_laser_dot_pattern_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_dot_pattern_gen.sv
// Raster test source with a red dot run; LASER_PATTERN_SWEEP_EN steps dot_x on each continuous restart.
// First beat 1 cycle after start; beats hold while out_ready or en is low.
`ifndef PIXEL_SIZE
`define PIXEL_SIZE 24
`endif

module laser_dot_pattern_gen #(
  parameter int PIXEL_SIZE = `PIXEL_SIZE,
  parameter int DIM_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [DIM_W-1:0]      frame_width,
  input  logic [DIM_W-1:0]      frame_height,
  input  logic [2*DIM_W-1:0]    dot_xy,
  input  logic [DIM_W-1:0]      dot_len,
  input  logic [PIXEL_SIZE-1:0] dot_color,
  input  logic [PIXEL_SIZE-1:0] bg_color,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DIM_W-1:0]      pixel_col,
  output logic [DIM_W-1:0]      pixel_row,
  output logic [PIXEL_SIZE-1:0] data,
  output logic                  sof,
  output logic                  eol,
  output logic                  busy,
  output logic [15:0]           frame_count
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  typedef struct packed {
    logic [DIM_W-1:0]      w;
    logic [DIM_W-1:0]      h;
    logic [DIM_W-1:0]      dot_x;
    logic [DIM_W-1:0]      dot_y;
    logic [DIM_W-1:0]      dot_len;
    logic [PIXEL_SIZE-1:0] dot_color;
    logic [PIXEL_SIZE-1:0] bg_color;
  } cfg_t;

  localparam logic [DIM_W-1:0] ONE = 1;

  state_t                state_q, state_d;
  cfg_t                  cfg_q, cfg_d, cfg_in;
  logic [DIM_W-1:0]      col_q, col_d, row_q, row_d;
  logic [PIXEL_SIZE-1:0] data_q, data_d;
  logic                  sof_q, sof_d, eol_q, eol_d;
  logic [15:0]           fc_q, fc_d;
  logic                  xfer, last, dims_ok, load;
`ifdef LASER_PATTERN_SWEEP_EN
  logic [DIM_W:0]        nx;
`endif

  // Run end is formed one bit wider so a run past the right edge clips instead of wrapping.
  function automatic logic [PIXEL_SIZE-1:0] pixel_of(input logic [DIM_W-1:0] c,
                                                     input logic [DIM_W-1:0] r,
                                                     input cfg_t cf);
    logic [DIM_W:0] run_end;
    run_end = {1'b0, cf.dot_x} + {1'b0, cf.dot_len};
    if (r == cf.dot_y && c >= cf.dot_x && {1'b0, c} < run_end) return cf.dot_color;
    return cf.bg_color;
  endfunction

  assign out_valid   = (state_q == ACTIVE) && en;
  assign busy        = (state_q != IDLE);
  assign pixel_col   = col_q;
  assign pixel_row   = row_q;
  assign data        = data_q;
  assign sof         = sof_q;
  assign eol         = eol_q;
  assign frame_count = fc_q;

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    col_d   = col_q;
    row_d   = row_q;
    data_d  = data_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    fc_d    = fc_q;
    load    = 1'b0;
    xfer    = out_valid && out_ready;
    last    = (col_q == cfg_q.w - ONE) && (row_q == cfg_q.h - ONE);
    dims_ok = (frame_width != '0) && (frame_height != '0);
    cfg_in  = '{w: frame_width, h: frame_height,
                dot_x: dot_xy[2*DIM_W-1:DIM_W], dot_y: dot_xy[DIM_W-1:0],
                dot_len: dot_len, dot_color: dot_color, bg_color: bg_color};
`ifdef LASER_PATTERN_SWEEP_EN
    nx = {1'b0, cfg_q.dot_x} + {1'b0, ONE};
`endif

    case (state_q)
      IDLE: begin
        if (en && start && dims_ok) begin
          state_d = ACTIVE;
          cfg_d   = cfg_in;
          col_d   = '0;
          row_d   = '0;
          load    = 1'b1;
        end
      end
      ACTIVE: begin
        if (xfer) begin
          if (last) begin
            fc_d = fc_q + 16'd1;
            if (continuous && start && dims_ok) begin
              cfg_d = cfg_in;
`ifdef LASER_PATTERN_SWEEP_EN
              cfg_d.dot_x = (nx >= {1'b0, cfg_in.w}) ? '0 : nx[DIM_W-1:0];
`endif
              col_d = '0;
              row_d = '0;
              load  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else if (col_q != cfg_q.w - ONE) begin
            col_d = col_q + ONE;
            load  = 1'b1;
          end else begin
            col_d = '0;
            row_d = row_q + ONE;
            load  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      data_d = pixel_of(col_d, row_d, cfg_d);
      sof_d  = (col_d == '0) && (row_d == '0);
      eol_d  = (col_d == cfg_d.w - ONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      data_q  <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      col_q   <= col_d;
      row_q   <= row_d;
      data_q  <= data_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      fc_q    <= fc_d;
    end
  end

endmodule

// File: tb/tb_laser_dot_pattern_gen.sv
// Scoreboard bench for laser_dot_pattern_gen: expected beats are queued per frame and compared as the source emits them.
module tb_laser_dot_pattern_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, start, continuous, out_ready;
  logic [15:0] frame_width, frame_height, dot_len;
  logic [31:0] dot_xy;
  logic [23:0] dot_color, bg_color;
  logic        out_valid, sof, eol, busy;
  logic [15:0] pixel_col, pixel_row, frame_count;
  logic [23:0] data;

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;
  int red_cnt = 0;
  int cyc     = 0;
  int first_x = 0;
  int last_x  = 0;
  logic [63:0] sb[$];

  laser_dot_pattern_gen dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .continuous(continuous),
    .frame_width(frame_width), .frame_height(frame_height), .dot_xy(dot_xy),
    .dot_len(dot_len), .dot_color(dot_color), .bg_color(bg_color),
    .out_ready(out_ready), .out_valid(out_valid), .pixel_col(pixel_col),
    .pixel_row(pixel_row), .data(data), .sof(sof), .eol(eol), .busy(busy),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat(input logic [15:0] c, input logic [15:0] r,
                                       input logic [23:0] d, input logic s, input logic e);
    return {6'b0, c, r, d, s, e};
  endfunction

  task automatic push_frame(input int w, input int h, input int dx, input int dy,
                            input int dl, input logic [23:0] dc, input logic [23:0] bg);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        bit red;
        red = (r == dy) && (c >= dx) && (c < dx + dl);
        sb.push_back(beat(16'(c), 16'(r), red ? dc : bg, (c == 0) && (r == 0), c == w - 1));
      end
  endtask

  // Every cycle the source is active, the presented beat must equal the scoreboard head.
  always @(negedge clk) begin
    cyc++;
    if (!reset && busy) begin
      chk("valid_vs_en", out_valid, en);
      if (sb.size() == 0) chk("beat_without_expect", sb.size(), 1);
      else begin
        chk((out_valid && out_ready) ? "beat" : "hold",
            beat(pixel_col, pixel_row, data, sof, eol), sb[0]);
        if (out_valid && out_ready) begin
          if (data == 24'hFF0000) red_cnt++;
          if (n_xfer == 0) first_x = cyc;
          last_x = cyc;
          n_xfer++;
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    sb.delete();
    n_xfer = 0;
  endtask

  task automatic run_until_idle(input bit rnd, input bit stall, input int drop_at);
    int sc;
    bit done;
    sc = 0;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      tick();
      if (n_xfer >= drop_at) start = 1'b0;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall && n_xfer >= 10 && sc < 5) begin
        en = 1'b0;
        sc++;
      end else en = 1'b1;
      if (!busy && !start) done = 1;
    end
    if (!done) chk("idle_timeout", busy, 0);
    out_ready = 1'b1;
    en = 1'b1;
  endtask

  task automatic set_cfg(input int w, input int h, input int dx, input int dy, input int dl);
    frame_width  = 16'(w);
    frame_height = 16'(h);
    dot_xy       = {16'(dx), 16'(dy)};
    dot_len      = 16'(dl);
  endtask

  initial begin
    int dx;
    bit found;
    reset = 1'b1; en = 1'b1; start = 1'b0; continuous = 1'b0; out_ready = 1'b1;
    dot_color = 24'hFF0000; bg_color = 24'h101010;
    set_cfg(8, 4, 3, 2, 3);
    repeat (2) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_col_row", {pixel_col, pixel_row}, 0);
    chk("rst_data", data, 0);
    chk("rst_sof_eol", {sof, eol}, 0);
    chk("rst_fc", frame_count, 0);
    reset = 1'b0;
    tick();

    // Basic frame, free-flowing
    n_xfer = 0; red_cnt = 0;
    push_frame(8, 4, 3, 2, 3, dot_color, bg_color);
    start = 1'b1;
    run_until_idle(0, 0, 0);
    chk("t1_beats", n_xfer, 32);
    chk("t1_red", red_cnt, 3);
    chk("t1_fc", frame_count, 1);
    chk("t1_sb_left", sb.size(), 0);

    // Same frame with random backpressure and an enable stall mid-row
    n_xfer = 0; red_cnt = 0;
    push_frame(8, 4, 3, 2, 3, dot_color, bg_color);
    start = 1'b1;
    run_until_idle(1, 1, 0);
    chk("t2_beats", n_xfer, 32);
    chk("t2_red", red_cnt, 3);
    chk("t2_fc", frame_count, 2);

    // Run clipped at the right edge
    n_xfer = 0; red_cnt = 0;
    set_cfg(8, 4, 6, 1, 5);
    push_frame(8, 4, 6, 1, 5, dot_color, bg_color);
    start = 1'b1;
    run_until_idle(0, 0, 0);
    chk("t3_red_clip", red_cnt, 2);
    chk("t3_fc", frame_count, 3);

    // Zero-dimension starts are ignored
    set_cfg(0, 4, 0, 0, 1);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("zw_busy", busy, 0);
      chk("zw_valid", out_valid, 0);
    end
    set_cfg(4, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("zh_busy", busy, 0);
      chk("zh_valid", out_valid, 0);
    end
    start = 1'b0;

    // Start held with en low waits; then a 1x1 frame
    set_cfg(1, 1, 0, 0, 1);
    en = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_low_busy", busy, 0);
    end
    n_xfer = 0;
    push_frame(1, 1, 0, 0, 1, dot_color, bg_color);
    en = 1'b1;
    run_until_idle(0, 0, 0);
    chk("t1x1_beats", n_xfer, 1);
    chk("t1x1_fc", frame_count, 4);

    // Continuous back-to-back frames
    do_reset();
    set_cfg(4, 2, 3, 0, 1);
    dx = 3;
    for (int f = 0; f < 3; f++) begin
      push_frame(4, 2, dx, 0, 1, dot_color, bg_color);
`ifdef LASER_PATTERN_SWEEP_EN
      dx = (dx + 1 >= 4) ? 0 : dx + 1;
`endif
    end
    continuous = 1'b1; start = 1'b1;
    run_until_idle(0, 0, 23);
    continuous = 1'b0;
    chk("cont_beats", n_xfer, 24);
    chk("cont_fc", frame_count, 3);
    chk("cont_span", last_x - first_x + 1, 24);
    chk("cont_sb_left", sb.size(), 0);

    // Reset mid-frame at beat (2,1)
    do_reset();
    set_cfg(4, 4, 1, 1, 2);
    push_frame(4, 4, 1, 1, 2, dot_color, bg_color);
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (pixel_col == 16'd2 && pixel_row == 16'd1) found = 1;
    end
    if (!found) chk("reach_2_1", {pixel_col, pixel_row}, {16'd2, 16'd1});
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fc", frame_count, 0);
    chk("mid_rst_col_row", {pixel_col, pixel_row}, 0);
    sb.delete();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    set_cfg(4, 2, 0, 0, 1);
    n_xfer = 0;
    push_frame(4, 2, 0, 0, 1, dot_color, bg_color);
    start = 1'b1;
    run_until_idle(0, 0, 0);
    chk("post_rst_beats", n_xfer, 8);
    chk("post_rst_fc", frame_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
